// File: rtl/bidirectional_deserializer.sv
// Serial-to-parallel receiver: MSB- or LSB-first framing with a valid/ready output register.
// Optional even-parity bit per frame when DESER_PARITY_EN is defined.
module bidirectional_deserializer #(
    parameter int WIDTH = 8,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             serialin,
    input  logic             shiftleft,
    input  logic             clear,
    input  logic             dataready,
    output logic [WIDTH-1:0] dataout,
    output logic             datavalid,
    output logic             overrun,
    output logic [CW-1:0]    bitcount,
    output logic             parityerr
);

`ifdef DESER_PARITY_EN
    typedef enum logic [1:0] {IDLE, RECV, PAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, RECV} state_t;
`endif

    state_t           state_q, state_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             perr_q, perr_d;

    logic             dir_eff;
    logic [WIDTH-1:0] shifted;
    logic             word_done;
    logic [WIDTH-1:0] word_new;
    logic             perr_new;

    // Direction is taken live on the first bit of a frame, latched thereafter.
    assign dir_eff = (state_q == IDLE) ? shiftleft : dir_q;
    assign shifted = dir_eff ? {sr_q[WIDTH-2:0], serialin}
                             : {serialin, sr_q[WIDTH-1:1]};

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        dout_d    = dout_q;
        valid_d   = valid_q;
        ovr_d     = ovr_q;
        perr_d    = perr_q;
        word_done = 1'b0;
        word_new  = '0;
        perr_new  = 1'b0;

        if (clear) begin
            state_d = IDLE;
            sr_d    = '0;
            cnt_d   = '0;
            ovr_d   = 1'b0;
        end else if (enable) begin
            case (state_q)
`ifdef DESER_PARITY_EN
                PAR: begin
                    word_done = 1'b1;
                    word_new  = sr_q;
                    perr_new  = (^sr_q) ^ serialin;
                    state_d   = IDLE;
                end
`endif
                default: begin
                    if (state_q == IDLE) begin
                        dir_d = shiftleft;
                    end
                    sr_d = shifted;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        cnt_d = '0;
`ifdef DESER_PARITY_EN
                        state_d = PAR;
`else
                        word_done = 1'b1;
                        word_new  = shifted;
                        state_d   = IDLE;
`endif
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                        state_d = RECV;
                    end
                end
            endcase
        end

        if (valid_q && dataready) begin
            valid_d = 1'b0;
        end

        // A word completing while the previous one is still held and not being taken is dropped.
        if (word_done) begin
            if (!valid_q || dataready) begin
                dout_d  = word_new;
                perr_d  = perr_new;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            dir_q   <= 1'b0;
            sr_q    <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            perr_q  <= perr_d;
        end
    end

    assign dataout   = dout_q;
    assign datavalid = valid_q;
    assign overrun   = ovr_q;
    assign bitcount  = cnt_q;
`ifdef DESER_PARITY_EN
    assign parityerr = perr_q;
`else
    assign parityerr = 1'b0;
`endif

endmodule

// File: tb/tb_bidirectional_deserializer.sv
// Directed self-checking bench for bidirectional_deserializer (WIDTH=8).
// Honours DESER_PARITY_EN by appending a parity bit to each frame.
module tb_bidirectional_deserializer;

    localparam int WIDTH = 8;
    localparam int CW    = $clog2(WIDTH + 1);

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             enable = 1'b0;
    logic             serialin = 1'b0;
    logic             shiftleft = 1'b0;
    logic             clear = 1'b0;
    logic             dataready = 1'b0;
    logic [WIDTH-1:0] dataout;
    logic             datavalid;
    logic             overrun;
    logic [CW-1:0]    bitcount;
    logic             parityerr;

    int n_checks = 0;
    int n_errors = 0;

    bidirectional_deserializer #(.WIDTH(WIDTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .serialin  (serialin),
        .shiftleft (shiftleft),
        .clear     (clear),
        .dataready (dataready),
        .dataout   (dataout),
        .datavalid (datavalid),
        .overrun   (overrun),
        .bitcount  (bitcount),
        .parityerr (parityerr)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic sl, input logic rdy);
        enable    = 1'b1;
        serialin  = b;
        shiftleft = sl;
        dataready = rdy;
        step();
        enable    = 1'b0;
        dataready = 1'b0;
    endtask

    // Sends a frame; dataready is raised only on the edge that completes it.
    task automatic send_frame(input logic [7:0] w, input logic msb, input logic rdy_last);
        logic last;
        for (int i = 0; i < 8; i++) begin
`ifdef DESER_PARITY_EN
            last = 1'b0;
`else
            last = (i == 7);
`endif
            send_bit(msb ? w[7-i] : w[i], msb, last ? rdy_last : 1'b0);
        end
`ifdef DESER_PARITY_EN
        send_bit(^w, msb, rdy_last);
`endif
        $display("frame 0x%02h msb_first=%0d -> dataout=0x%02h valid=%0d overrun=%0d",
                 w, msb, dataout, datavalid, overrun);
    endtask

    task automatic send_parity(input logic p);
`ifdef DESER_PARITY_EN
        send_bit(p, 1'b0, 1'b0);
`else
        if (p === 1'bx) $display("parity bit ignored");
`endif
    endtask

    task automatic consume(input logic [7:0] exp_word, input string tag);
        dataready = 1'b1;
        step();
        dataready = 1'b0;
        check({tag, "_valid_after_take"}, {31'b0, datavalid}, 32'd0);
        check({tag, "_dout_kept"}, {24'b0, dataout}, {24'b0, exp_word});
        $display("consume 0x%02h", exp_word);
    endtask

    initial begin
        logic [7:0] seq;
        logic [7:0] w81;
        seq = 8'b1100_0000;
        w81 = 8'h81;

        // Power-on reset
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        check("rst_dout", {24'b0, dataout}, 32'h00);
        check("rst_valid", {31'b0, datavalid}, 32'd0);
        check("rst_ovr", {31'b0, overrun}, 32'd0);
        check("rst_bc", {28'b0, bitcount}, 32'd0);
        check("rst_perr", {31'b0, parityerr}, 32'd0);

        // Reset mid-frame after five bits
        for (int i = 0; i < 5; i++) send_bit(i[0], 1'b1, 1'b0);
        check("mid_bc5", {28'b0, bitcount}, 32'd5);
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        check("mid_rst_dout", {24'b0, dataout}, 32'h00);
        check("mid_rst_valid", {31'b0, datavalid}, 32'd0);
        check("mid_rst_ovr", {31'b0, overrun}, 32'd0);
        check("mid_rst_bc", {28'b0, bitcount}, 32'd0);
        send_frame(8'h3C, 1'b1, 1'b0);
        check("post_rst_dout", {24'b0, dataout}, 32'h3C);
        check("post_rst_valid", {31'b0, datavalid}, 32'd1);
        consume(8'h3C, "post_rst");

        // MSB-first 1,1,0,0,0,0,0,0 with bitcount tracking
        for (int i = 0; i < 8; i++) begin
            send_bit(seq[7-i], 1'b1, 1'b0);
            check($sformatf("msb_bc%0d", i + 1), {28'b0, bitcount}, (i == 7) ? 32'd0 : i + 1);
        end
        send_parity(1'b0);
        check("msb_dout", {24'b0, dataout}, 32'hC0);
        check("msb_valid", {31'b0, datavalid}, 32'd1);
        $display("frame msb-first bits 11000000 -> dataout=0x%02h", dataout);
        consume(8'hC0, "msb");

        // LSB-first, shiftleft toggled on bits 3-5 must be ignored
        for (int i = 0; i < 8; i++) begin
            send_bit(seq[7-i], (i >= 2 && i <= 4) ? 1'b1 : 1'b0, 1'b0);
        end
        send_parity(1'b0);
        check("lsb_dout", {24'b0, dataout}, 32'h03);
        check("lsb_valid", {31'b0, datavalid}, 32'd1);
        $display("frame lsb-first bits 11000000 -> dataout=0x%02h", dataout);
        consume(8'h03, "lsb");

        // Backpressure and overrun
        send_frame(8'h11, 1'b1, 1'b0);
        check("bp_first_dout", {24'b0, dataout}, 32'h11);
        check("bp_first_ovr", {31'b0, overrun}, 32'd0);
        send_frame(8'h22, 1'b1, 1'b0);
        check("bp_dout_held", {24'b0, dataout}, 32'h11);
        check("bp_valid_held", {31'b0, datavalid}, 32'd1);
        check("bp_ovr_set", {31'b0, overrun}, 32'd1);
        consume(8'h11, "bp");
        check("bp_ovr_sticky", {31'b0, overrun}, 32'd1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("bp_ovr_cleared", {31'b0, overrun}, 32'd0);
        check("bp_clear_bc", {28'b0, bitcount}, 32'd0);

        // Completion on the same edge as a transfer
        send_frame(8'h5A, 1'b1, 1'b0);
        check("b2b_first_dout", {24'b0, dataout}, 32'h5A);
        send_frame(8'hA5, 1'b1, 1'b1);
        check("b2b_valid", {31'b0, datavalid}, 32'd1);
        check("b2b_dout", {24'b0, dataout}, 32'hA5);
        check("b2b_ovr", {31'b0, overrun}, 32'd0);
        consume(8'hA5, "b2b");

        // Clear together with enable discards the bit, then gapped 0x81
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0);
        clear = 1'b1;
        send_bit(1'b1, 1'b1, 1'b0);
        clear = 1'b0;
        check("clr_bc", {28'b0, bitcount}, 32'd0);
        check("clr_valid", {31'b0, datavalid}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                serialin = 1'($urandom_range(0, 1));
                step();
            end
            send_bit(w81[7-i], 1'b1, 1'b0);
        end
        serialin = 1'b1;
        step();
        step();
        check("gap_bc", {28'b0, bitcount}, 32'd0);
`ifdef DESER_PARITY_EN
        check("par_pending_valid", {31'b0, datavalid}, 32'd0);
        send_bit(1'b1, 1'b1, 1'b0);
        check("par1_dout", {24'b0, dataout}, 32'h81);
        check("par1_perr", {31'b0, parityerr}, 32'd1);
        consume(8'h81, "par1");
        send_frame(8'h81, 1'b1, 1'b0);
        check("par0_dout", {24'b0, dataout}, 32'h81);
        check("par0_perr", {31'b0, parityerr}, 32'd0);
`else
        check("gap_dout", {24'b0, dataout}, 32'h81);
        check("gap_valid", {31'b0, datavalid}, 32'd1);
        check("gap_perr", {31'b0, parityerr}, 32'd0);
`endif
        $display("frame 0x81 with gaps -> dataout=0x%02h parityerr=%0d", dataout, parityerr);
        consume(8'h81, "gap");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/bidirectional_deserializer.md
Name: bidirectional_deserializer

Overview:
- Receive-side counterpart of the parallel-load bidirectional shift register: collects a serial bit stream into WIDTH-bit words.
- Supports MSB-first and LSB-first framing.
- Presents each completed word on a registered parallel output with a valid/ready handshake.
- Sits at the receive end of the team's serial links, feeding parallel datapath consumers.

Parameters:
- WIDTH, 8, word width in bits; legal values are 2 or more.
- CW (localparam), $clog2(WIDTH+1), width of the bit counter.

Ports:
- clock  input  1  sole clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  serialin is a valid bit this cycle.
- serialin  input  1  serial data bit.
- shiftleft  input  1  frame order: 1 = MSB-first (shift left, insert at LSB); 0 = LSB-first (shift right, insert at MSB).
- clear  input  1  synchronous abort of the partial frame.
- dataready  input  1  consumer accepts dataout.
- dataout  output  WIDTH  last completed word, registered.
- datavalid  output  1  dataout holds an unconsumed word.
- overrun  output  1  sticky flag: a completed word was dropped.
- bitcount  output  CW  number of bits collected in the current frame (0..WIDTH-1).
- parityerr  output  1  parity flag for dataout (see Optional Feature).

Behaviour:
- Reset (synchronous, clock edge with reset=1) clears all state:
  - dataout=0, datavalid=0, overrun=0, bitcount=0, parityerr=0.
  - Internal shift register = 0; FSM = IDLE.
  - Reset overrides every other input and aborts any partial frame.
- FSM states:
  - IDLE (bitcount==0).
  - RECV (1 ≤ bitcount ≤ WIDTH-1).
  - PAR (parity bit pending; exists only with the macro).
- Accepting a bit (enable=1, clear=0):
  - In IDLE: latch shiftleft as the frame direction, shift the bit in, bitcount=1, go to RECV.
  - In RECV: shift the bit in using the latched direction; shiftleft is ignored until the next frame; bitcount++.
  - Shift left: sr <= {sr[WIDTH-2:0], serialin}. Shift right: sr <= {serialin, sr[WIDTH-1:1]}.
- Frame completion: the edge that accepts the WIDTH-th data bit completes the frame.
  - bitcount returns to 0; FSM goes to IDLE (or PAR with the macro).
  - The assembled word, including the final bit, is offered to the output register at that same edge.
  - Latency: the word is visible on dataout in the cycle right after the last bit's edge.
- enable=0: state holds; bitcount and the shift register are unchanged. Gaps between bits are unlimited.
- Output handshake:
  - A transfer happens on an edge where datavalid=1 and dataready=1.
  - dataout is stable while datavalid=1 and no transfer occurs.
  - After a transfer with no new word, datavalid=0 on the next cycle; dataout keeps its last value.
  - A transfer and a completion on the same edge: the new word loads, datavalid stays 1, no overrun.
- Overrun:
  - Completion with datavalid=1 and dataready=0: the new word is discarded, dataout and datavalid are unchanged, overrun is set to 1.
  - overrun clears only on reset or clear.
- clear=1:
  - Next cycle: bitcount=0, shift register=0, FSM=IDLE, overrun=0.
  - dataout and datavalid are unaffected, so a pending word can still be consumed.
  - clear and enable on the same edge: clear wins; the bit is discarded.
- bitcount is registered and reflects accepted bits only.

Optional Feature:
- Macro: DESER_PARITY_EN.
- With the macro defined:
  - Each frame is WIDTH data bits followed by one even-parity bit.
  - After the WIDTH-th data bit the FSM enters PAR; the next accepted bit is the parity bit.
  - bitcount stays at 0 while in PAR.
  - The word is offered to the output register on the edge that accepts the parity bit, not on the WIDTH-th data bit.
  - parityerr is loaded alongside dataout: 1 when XOR(data, parity) = 1. It has the same valid/hold rules as dataout and is discarded with the word on overrun.
  - clear in PAR returns the FSM to IDLE.
- Without the macro: frames are exactly WIDTH bits, the PAR state does not exist, and parityerr is constant 0.

Test Plan (WIDTH=8):
- Reset: hold reset 2 cycles mid-frame after 5 bits -> dataout=0x00, datavalid=0, overrun=0, bitcount=0; a following full 8-bit frame assembles correctly.
- MSB-first: shiftleft=1, enable each cycle, bits 1,1,0,0,0,0,0,0 -> dataout=0xC0 and datavalid=1 one cycle after the 8th bit; bitcount runs 1..7 then 0.
- LSB-first with mid-frame flip: shiftleft=0 at first bit, toggled on bits 3-5, same bit sequence -> dataout=0x03 (direction latched at frame start).
- Backpressure: dataready=0, frames 0x11 then 0x22 -> dataout=0x11, datavalid=1, overrun=1; raise dataready -> datavalid=0 next cycle; assert clear -> overrun=0.
- Back-to-back with simultaneous transfer: dataready=1, frames 0x5A then 0xA5 with the second completing on the edge 0x5A transfers -> datavalid stays 1, dataout=0xA5, overrun=0.
- Clear and gaps: 3 bits, clear together with enable, then 8 bits of 0x81 with random enable gaps -> dataout=0x81, the bit accepted with clear is discarded; with DESER_PARITY_EN, 0x81 followed by parity 1 -> parityerr=1, parity 0 -> parityerr=0.
